// File: rtl/cpu16.sv
// Single-cycle 16-bit load/store CPU, four registers, unified 256x16 RAM with a program-load port.
// Latency: one instruction retires per clk edge; backpressure: none, the core never stalls.
module cpu16 #(
  parameter int MEM_DEPTH = 256,
  parameter int DATA_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              prog_we,
  input  logic [7:0]        prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [7:0]        pc_address,
  output logic [DATA_W-1:0] current_instruction,
  output logic [DATA_W-1:0] r0_out,
  output logic [DATA_W-1:0] r1_out,
  output logic [DATA_W-1:0] r2_out,
  output logic [DATA_W-1:0] r3_out
);

  typedef enum logic [3:0] {
    OP_NOP   = 4'h0,
    OP_LOADI = 4'h1,
    OP_LOAD  = 4'h2,
    OP_STORE = 4'h3,
    OP_ADD   = 4'h4,
    OP_SUB   = 4'h5,
    OP_AND   = 4'h6,
    OP_OR    = 4'h7,
    OP_JUMP  = 4'h8,
    OP_XOR   = 4'h9,
    OP_NOT   = 4'ha,
    OP_SHL   = 4'hb,
    OP_SHR   = 4'hc,
    OP_MOV   = 4'hd,
    OP_BNE   = 4'he,
    OP_BEQ   = 4'hf
  } opcode_t;

  logic [DATA_W-1:0] mem  [MEM_DEPTH];
  logic [DATA_W-1:0] regs [4];
  logic [7:0]        pc;

  logic [DATA_W-1:0] instr;
  opcode_t           op;
  logic [1:0]        rd;
  logic [1:0]        rs;
  logic [7:0]        imm;
  logic [DATA_W-1:0] rd_val;
  logic [DATA_W-1:0] rs_val;

  logic              wb_en;
  logic [DATA_W-1:0] wb_val;
  logic              st_en;
  logic [7:0]        pc_next;

  logic              mem_we;
  logic [7:0]        mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  // Fetch, operand read and LOAD data are all combinational off the RAM array.
  assign instr  = mem[pc];
  assign op     = opcode_t'(instr[15:12]);
  assign rd     = instr[11:10];
  assign rs     = instr[9:8];
  assign imm    = instr[7:0];
  assign rd_val = regs[rd];
  assign rs_val = regs[rs];

  always_comb begin
    wb_en   = 1'b0;
    wb_val  = rd_val;
    st_en   = 1'b0;
    pc_next = pc + 8'd1;
    case (op)
      OP_NOP:   ;
      OP_LOADI: begin wb_en = 1'b1; wb_val = DATA_W'(imm);       end
      OP_LOAD:  begin wb_en = 1'b1; wb_val = mem[imm];           end
      OP_STORE: st_en = 1'b1;
      OP_ADD:   begin wb_en = 1'b1; wb_val = rd_val + rs_val;    end
      OP_SUB:   begin wb_en = 1'b1; wb_val = rd_val - rs_val;    end
      OP_AND:   begin wb_en = 1'b1; wb_val = rd_val & rs_val;    end
      OP_OR:    begin wb_en = 1'b1; wb_val = rd_val | rs_val;    end
      OP_JUMP:  pc_next = imm;
      OP_XOR:   begin wb_en = 1'b1; wb_val = rd_val ^ rs_val;    end
      OP_NOT:   begin wb_en = 1'b1; wb_val = ~rs_val;            end
      OP_SHL:   begin wb_en = 1'b1; wb_val = rd_val << 1;        end
      OP_SHR:   begin wb_en = 1'b1; wb_val = rd_val >> 1;        end
      OP_MOV:   begin wb_en = 1'b1; wb_val = rs_val;             end
      OP_BNE:   if (rd_val != rs_val) pc_next = imm;
      OP_BEQ:   if (rd_val == rs_val) pc_next = imm;
      default:  ;
    endcase
  end

  // Program load beats a same-edge STORE; a STORE seen while reset is low is dropped.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = imm;
    mem_wdata = rd_val;
    if (prog_we) begin
      mem_we    = 1'b1;
      mem_waddr = prog_addr;
      mem_wdata = prog_data;
    end else if (st_en && reset) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= '0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      pc <= pc_next;
      if (wb_en) regs[rd] <= wb_val;
    end
  end

  assign pc_address          = pc;
  assign current_instruction = instr;
  assign r0_out              = regs[0];
  assign r1_out              = regs[1];
  assign r2_out              = regs[2];
  assign r3_out              = regs[3];

endmodule

// File: tb/tb_cpu16.sv
// Directed bench for cpu16: programs RAM under reset, runs, checks registers/PC/RAM.
module tb_cpu16;

  logic        clk = 1'b0;
  logic        reset;
  logic        prog_we;
  logic [7:0]  prog_addr;
  logic [15:0] prog_data;
  logic [7:0]  pc_address;
  logic [15:0] current_instruction;
  logic [15:0] r0_out, r1_out, r2_out, r3_out;

  int n_checks = 0;
  int n_pass   = 0;

  cpu16 dut (
    .clk                 (clk),
    .reset               (reset),
    .prog_we             (prog_we),
    .prog_addr           (prog_addr),
    .prog_data           (prog_data),
    .pc_address          (pc_address),
    .current_instruction (current_instruction),
    .r0_out              (r0_out),
    .r1_out              (r1_out),
    .r2_out              (r2_out),
    .r3_out              (r3_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // All drive/sample happens just after a falling edge.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_mem(input logic [7:0] a, input logic [15:0] d);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = d;
    @(negedge clk);
    prog_we   = 1'b0;
  endtask

  task automatic reset_and_clear();
    reset = 1'b0;
    for (int i = 0; i < 256; i++) write_mem(8'(i), 16'h0000);
  endtask

  initial begin
    reset     = 1'b0;
    prog_we   = 1'b0;
    prog_addr = 8'h00;
    prog_data = 16'h0000;
    @(negedge clk);

    // Reset and load
    reset_and_clear();
    write_mem(8'd0, 16'h1005);
    write_mem(8'd1, 16'h1403);
    write_mem(8'd2, 16'h4100);
    check("rst_pc", {8'h00, pc_address}, 16'h0000);
    check("rst_r0", r0_out, 16'h0000);
    check("rst_r1", r1_out, 16'h0000);
    check("rst_r2", r2_out, 16'h0000);
    check("rst_r3", r3_out, 16'h0000);
    check("rst_instr", current_instruction, 16'h1005);
    reset = 1'b1;
    step(3);
    check("load_r0", r0_out, 16'h0008);
    check("load_r1", r1_out, 16'h0003);
    check("load_pc", {8'h00, pc_address}, 16'h0003);

    // Branch/jump flow
    reset_and_clear();
    write_mem(8'd0, 16'h4000);
    write_mem(8'd1, 16'h4400);
    write_mem(8'd2, 16'h8003);
    write_mem(8'd3, 16'hF104);
    reset = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      check($sformatf("flow_pc%0d", k), {8'h00, pc_address}, 16'(k));
      if (k < 6) step(1);
    end
    check("flow_r0", r0_out, 16'h0000);
    check("flow_r1", r1_out, 16'h0000);

    // BNE not taken / taken
    reset_and_clear();
    write_mem(8'd0, 16'h1007);
    write_mem(8'd1, 16'h1407);
    write_mem(8'd2, 16'hE120);
    write_mem(8'd3, 16'h1408);
    write_mem(8'd4, 16'hE120);
    reset = 1'b1;
    step(3);
    check("bne_nt_pc", {8'h00, pc_address}, 16'h0003);
    step(2);
    check("bne_t_pc", {8'h00, pc_address}, 16'h0020);

    // Memory
    reset_and_clear();
    write_mem(8'd0, 16'h18AB);
    write_mem(8'd1, 16'h3880);
    write_mem(8'd2, 16'h2C80);
    reset = 1'b1;
    step(3);
    check("mem_r2", r2_out, 16'h00AB);
    check("mem_r3", r3_out, 16'h00AB);
    check("mem_ram80", dut.mem[8'h80], 16'h00AB);

    // ALU wrap, shifts, logic ops
    reset_and_clear();
    write_mem(8'd0, 16'h10FF);
    for (int i = 1; i <= 8; i++) write_mem(8'(i), 16'hB000);
    write_mem(8'd9,  16'h18FF);
    write_mem(8'd10, 16'h7200);
    write_mem(8'd11, 16'h1401);
    write_mem(8'd12, 16'h4100);
    write_mem(8'd13, 16'h5100);
    write_mem(8'd14, 16'h1C80);
    for (int i = 15; i <= 22; i++) write_mem(8'(i), 16'hBC00);
    write_mem(8'd23, 16'hCC00);
    write_mem(8'd24, 16'hA600);
    write_mem(8'd25, 16'hD300);
    write_mem(8'd26, 16'h6100);
    write_mem(8'd27, 16'h9200);
    reset = 1'b1;
    step(11);
    check("alu_ffff", r0_out, 16'hFFFF);
    step(2);
    check("alu_add_wrap", r0_out, 16'h0000);
    step(1);
    check("alu_sub_wrap", r0_out, 16'hFFFF);
    step(10);
    check("alu_shr", r3_out, 16'h4000);
    step(1);
    check("alu_not", r1_out, 16'hFF00);
    step(1);
    check("alu_mov", r0_out, 16'h4000);
    step(1);
    check("alu_and", r0_out, 16'h4000);
    step(1);
    check("alu_xor", r0_out, 16'h40FF);
    check("alu_pc", {8'h00, pc_address}, 16'h001C);

    // PC wrap, mid-run reset, STORE suppressed under reset, prog_we beats STORE
    reset_and_clear();
    write_mem(8'd1,   16'h1855);
    write_mem(8'h90,  16'h1234);
    reset = 1'b1;
    step(2);
    check("wrap_r2", r2_out, 16'h0055);
    step(253);
    check("wrap_pc255", {8'h00, pc_address}, 16'h00FF);
    step(1);
    check("wrap_pc0", {8'h00, pc_address}, 16'h0000);
    step(1);
    reset = 1'b0;
    #1;
    check("midrst_pc", {8'h00, pc_address}, 16'h0000);
    check("midrst_r2", r2_out, 16'h0000);
    write_mem(8'd0, 16'h3890);
    check("midrst_instr", current_instruction, 16'h3890);
    step(2);
    check("midrst_store_blocked", dut.mem[8'h90], 16'h1234);
    check("midrst_pc_held", {8'h00, pc_address}, 16'h0000);
    reset = 1'b1;
    write_mem(8'h90, 16'hBEEF);
    check("progwe_wins", dut.mem[8'h90], 16'hBEEF);
    check("progwe_pc", {8'h00, pc_address}, 16'h0001);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
